// File: rtl/div_state_counter_pkg.sv
// Shared constants for the fractional-N feedback divider state counter.
// Count limits and modulus-select encodings used by RTL and bench.
package div_pkg;

    localparam logic [3:0] CNT_MAX    = 4'd15;
    localparam logic [3:0] CNT_HALF   = 4'd8;
    localparam logic       SEL_DIV240 = 1'b1;
    localparam logic       SEL_DIV248 = 1'b0;

endpackage

// File: rtl/div_state_counter_if.sv
// Control/status bundle between the divider state counter and its neighbours.
// master drives enable and modulus request; slave returns the state bits.
interface div_state_counter_if;

    logic en;
    logic sel_req;
    logic a;
    logic b;
    logic c;
    logic d;
    logic c_bar;
    logic d_bar;
    logic select_in;
    logic tc;
    logic fdiv;
    logic sel_chg;

    modport master (
        output en, sel_req,
        input  a, b, c, d, c_bar, d_bar,
        input  select_in, tc, fdiv, sel_chg
    );

    modport slave (
        input  en, sel_req,
        output a, b, c, d, c_bar, d_bar,
        output select_in, tc, fdiv, sel_chg
    );

endinterface

// File: rtl/div_state_counter_sel_sync.sv
// N-stage resettable bit synchronizer for the asynchronous modulus request.
// Stages reset to a programmable value so the mode is defined out of reset.
module sel_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (STAGES < 2 || STAGES > 4) begin : g_bad_depth
        $error("sel_sync: STAGES must be 2..4");
    end

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/div_state_counter.sv
// Four-bit state counter feeding the modulus controller and the PFD.
// Mode bit is only reloaded on the 15->0 wrap so a period never mixes moduli.
module div_state_counter
    import div_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter logic SEL_RESET   = SEL_DIV240
) (
    input  logic                clk,
    input  logic                rst_n,
    div_state_counter_if.slave  bus
);

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       c_bar_q;
    logic       d_bar_q;
    logic       sel_q;
    logic       chg_q;
    logic       fdiv_q;
    logic       sel_s;
    logic       wrap;

    sel_sync #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (SEL_RESET)
    ) u_sel_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.sel_req),
        .q     (sel_s)
    );

    assign wrap    = bus.en && (cnt == CNT_MAX);
    assign cnt_nxt = bus.en ? cnt + 4'd1 : cnt;

    // Complements and fdiv come from the next count so they stay glitch-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 4'd0;
            c_bar_q <= 1'b1;
            d_bar_q <= 1'b1;
            fdiv_q  <= 1'b1;
            sel_q   <= SEL_RESET;
            chg_q   <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            c_bar_q <= ~cnt_nxt[1];
            d_bar_q <= ~cnt_nxt[0];
            fdiv_q  <= (cnt_nxt < CNT_HALF);
            chg_q   <= wrap && (sel_s != sel_q);
            if (wrap) begin
                sel_q <= sel_s;
            end
        end
    end

    assign bus.a         = cnt[3];
    assign bus.b         = cnt[2];
    assign bus.c         = cnt[1];
    assign bus.d         = cnt[0];
    assign bus.c_bar     = c_bar_q;
    assign bus.d_bar     = d_bar_q;
    assign bus.select_in = sel_q;
    assign bus.sel_chg   = chg_q;
    assign bus.fdiv      = fdiv_q;
    assign bus.tc        = wrap;

endmodule
